// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with stall/flush control, load-use hazard detection
// and saturating stall/bubble counters for performance debug.
module id_exe_pipe_reg #(
   parameter int DSIZE  = 16,
   parameter int ISIZE  = 16,
   parameter int ASIZE  = 3,
   parameter int OPSIZE = 3,
   parameter int CNTW   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              flush_in,
   input  logic              valid_in,
   input  logic              wen_in,
   input  logic              branch_in,
   input  logic              mem_to_reg_in,
   input  logic              mem_write_in,
   input  logic              mem_read_in,
   input  logic [ISIZE-1:0]  nPC_in,
   input  logic [DSIZE-1:0]  imm_extended_in,
   input  logic [DSIZE-1:0]  rdata1_in,
   input  logic [DSIZE-1:0]  rdata2_imm_sel_in,
   input  logic [DSIZE-1:0]  rdata2_in,
   input  logic [OPSIZE-1:0] opcode_in,
   input  logic [ASIZE-1:0]  waddr_in,
   input  logic [ASIZE-1:0]  rs1_in,
   input  logic [ASIZE-1:0]  rs2_in,
   input  logic              rs2_used_in,
   output logic              valid_out,
   output logic              wen_out,
   output logic              branch_out,
   output logic              mem_to_reg_out,
   output logic              mem_write_out,
   output logic              mem_read_out,
   output logic [ISIZE-1:0]  nPC_out,
   output logic [DSIZE-1:0]  imm_extended_out,
   output logic [DSIZE-1:0]  alu_in1,
   output logic [DSIZE-1:0]  alu_in2,
   output logic [DSIZE-1:0]  rdata2_out,
   output logic [OPSIZE-1:0] opcode_out,
   output logic [ASIZE-1:0]  waddr_out,
   output logic              hazard_stall,
   output logic [CNTW-1:0]   stall_cnt,
   output logic [CNTW-1:0]   bubble_cnt
);

   // Control bits packed as {wen, branch, mem_to_reg, mem_write, mem_read}
   logic              valid_q, valid_d;
   logic [4:0]        ctl_q, ctl_d;
   logic [ISIZE-1:0]  npc_q, npc_d;
   logic [DSIZE-1:0]  imm_q, imm_d;
   logic [DSIZE-1:0]  alu1_q, alu1_d;
   logic [DSIZE-1:0]  alu2_q, alu2_d;
   logic [DSIZE-1:0]  rdata2_q, rdata2_d;
   logic [OPSIZE-1:0] opcode_q, opcode_d;
   logic [ASIZE-1:0]  waddr_q, waddr_d;
   logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNTW-1:0]   bubble_cnt_q, bubble_cnt_d;
   logic              load_use;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
   endfunction

   // EXE holds a real load writing a non-zero register that ID reads
   always_comb begin
      load_use = valid_q & ctl_q[0] & ctl_q[4] & (waddr_q != '0) & valid_in &
                 ((waddr_q == rs1_in) | (rs2_used_in & (waddr_q == rs2_in)));
   end

   assign hazard_stall = load_use & ~stall_in & ~rst;

   always_comb begin
      valid_d      = valid_q;
      ctl_d        = ctl_q;
      npc_d        = npc_q;
      imm_d        = imm_q;
      alu1_d       = alu1_q;
      alu2_d       = alu2_q;
      rdata2_d     = rdata2_q;
      opcode_d     = opcode_q;
      waddr_d      = waddr_q;
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall_in) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end else if (flush_in || hazard_stall) begin
         // Bubble: squash valid/control, data fields are don't-care and hold
         valid_d      = 1'b0;
         ctl_d        = '0;
         bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else begin
         valid_d  = valid_in;
         ctl_d    = {wen_in, branch_in, mem_to_reg_in, mem_write_in, mem_read_in} & {5{valid_in}};
         npc_d    = nPC_in;
         imm_d    = imm_extended_in;
         alu1_d   = rdata1_in;
         alu2_d   = rdata2_imm_sel_in;
         rdata2_d = rdata2_in;
         opcode_d = opcode_in;
         waddr_d  = waddr_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         ctl_q        <= '0;
         npc_q        <= '0;
         imm_q        <= '0;
         alu1_q       <= '0;
         alu2_q       <= '0;
         rdata2_q     <= '0;
         opcode_q     <= '0;
         waddr_q      <= '0;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         ctl_q        <= ctl_d;
         npc_q        <= npc_d;
         imm_q        <= imm_d;
         alu1_q       <= alu1_d;
         alu2_q       <= alu2_d;
         rdata2_q     <= rdata2_d;
         opcode_q     <= opcode_d;
         waddr_q      <= waddr_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign valid_out        = valid_q;
   assign wen_out          = ctl_q[4];
   assign branch_out       = ctl_q[3];
   assign mem_to_reg_out   = ctl_q[2];
   assign mem_write_out    = ctl_q[1];
   assign mem_read_out     = ctl_q[0];
   assign nPC_out          = npc_q;
   assign imm_extended_out = imm_q;
   assign alu_in1          = alu1_q;
   assign alu_in2          = alu2_q;
   assign rdata2_out       = rdata2_q;
   assign opcode_out       = opcode_q;
   assign waddr_out        = waddr_q;
   assign stall_cnt        = stall_cnt_q;
   assign bubble_cnt       = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Bench for id_exe_pipe_reg: table of stimulus records with hand-derived outcomes,
// expected outputs queued at drive time and checked after the clock edge.
module tb_id_exe_pipe_reg;

   localparam logic [1:0] K_RST = 2'd0, K_LOAD = 2'd1, K_HOLD = 2'd2, K_BUB = 2'd3;
   localparam int NV = 23;

   typedef struct {
      logic [3:0]  mode;   // {rst, stall, flush, valid}
      logic [4:0]  ctl;    // {wen, branch, mem_to_reg, mem_write, mem_read}
      logic [15:0] npc;
      logic [15:0] imm;
      logic [2:0]  op;
      logic [2:0]  wa;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic        rs2u;
      logic [1:0]  kind;
      logic        hz;
      logic [3:0]  stc;
      logic [3:0]  bub;
   } vec_t;

   typedef struct packed {
      logic        vld;
      logic [4:0]  ctl;
      logic [15:0] npc;
      logic [15:0] imm;
      logic [15:0] a1;
      logic [15:0] a2;
      logic [15:0] r2;
      logic [2:0]  op;
      logic [2:0]  wa;
      logic [3:0]  stc;
      logic [3:0]  bub;
   } out_t;

   logic        clk = 1'b0;
   logic        rst, stall_in, flush_in, valid_in;
   logic        wen_in, branch_in, mem_to_reg_in, mem_write_in, mem_read_in;
   logic [15:0] nPC_in, imm_extended_in, rdata1_in, rdata2_imm_sel_in, rdata2_in;
   logic [2:0]  opcode_in, waddr_in, rs1_in, rs2_in;
   logic        rs2_used_in;
   logic        valid_out, wen_out, branch_out, mem_to_reg_out, mem_write_out, mem_read_out;
   logic [15:0] nPC_out, imm_extended_out, alu_in1, alu_in2, rdata2_out;
   logic [2:0]  opcode_out, waddr_out;
   logic        hazard_stall;
   logic [3:0]  stall_cnt, bubble_cnt;

   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t tbl [NV];
   out_t sb_q [$];
   out_t prev_exp;

   always #5 clk = ~clk;

   id_exe_pipe_reg #(.DSIZE(16), .ISIZE(16), .ASIZE(3), .OPSIZE(3), .CNTW(4)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
      .wen_in(wen_in), .branch_in(branch_in), .mem_to_reg_in(mem_to_reg_in),
      .mem_write_in(mem_write_in), .mem_read_in(mem_read_in), .nPC_in(nPC_in),
      .imm_extended_in(imm_extended_in), .rdata1_in(rdata1_in),
      .rdata2_imm_sel_in(rdata2_imm_sel_in), .rdata2_in(rdata2_in), .opcode_in(opcode_in),
      .waddr_in(waddr_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rs2_used_in(rs2_used_in),
      .valid_out(valid_out), .wen_out(wen_out), .branch_out(branch_out),
      .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
      .mem_read_out(mem_read_out), .nPC_out(nPC_out), .imm_extended_out(imm_extended_out),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .rdata2_out(rdata2_out), .opcode_out(opcode_out),
      .waddr_out(waddr_out), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt),
      .bubble_cnt(bubble_cnt)
   );

   function automatic out_t actual();
      out_t a;
      a.vld = valid_out;
      a.ctl = {wen_out, branch_out, mem_to_reg_out, mem_write_out, mem_read_out};
      a.npc = nPC_out;
      a.imm = imm_extended_out;
      a.a1  = alu_in1;
      a.a2  = alu_in2;
      a.r2  = rdata2_out;
      a.op  = opcode_out;
      a.wa  = waddr_out;
      a.stc = stall_cnt;
      a.bub = bubble_cnt;
      return a;
   endfunction

   // Operand buses are derived from nPC/imm so each record stays compact
   task automatic drive(input vec_t v);
      {rst, stall_in, flush_in, valid_in} = v.mode;
      {wen_in, branch_in, mem_to_reg_in, mem_write_in, mem_read_in} = v.ctl;
      nPC_in            = v.npc;
      imm_extended_in   = v.imm;
      rdata1_in         = v.imm ^ 16'h00ff;
      rdata2_imm_sel_in = ~v.imm;
      rdata2_in         = v.npc + v.imm;
      opcode_in         = v.op;
      waddr_in          = v.wa;
      rs1_in            = v.rs1;
      rs2_in            = v.rs2;
      rs2_used_in       = v.rs2u;
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b", name, act, req);
      end
   endtask

   task automatic check_cnt(input string name, input logic [3:0] act, input logic [3:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal;
   end

   initial begin
      out_t e, a;
      tbl[0]  = '{4'b1111, 5'b11111, 16'hffff, 16'hffff, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, K_RST,  1'b0, 4'd0, 4'd0};
      tbl[1]  = tbl[0];
      tbl[2]  = '{4'b0001, 5'b10000, 16'h0010, 16'h1111, 3'd3, 3'd2, 3'd0, 3'd0, 1'b0, K_LOAD, 1'b0, 4'd0, 4'd0};
      tbl[3]  = '{4'b0001, 5'b10001, 16'h0011, 16'h2222, 3'd4, 3'd3, 3'd2, 3'd0, 1'b0, K_LOAD, 1'b0, 4'd0, 4'd0};
      tbl[4]  = '{4'b0001, 5'b10000, 16'h0012, 16'h3333, 3'd1, 3'd4, 3'd3, 3'd0, 1'b0, K_BUB,  1'b1, 4'd0, 4'd1};
      tbl[5]  = '{4'b0001, 5'b10000, 16'h0012, 16'h3333, 3'd1, 3'd4, 3'd3, 3'd0, 1'b0, K_LOAD, 1'b0, 4'd0, 4'd1};
      tbl[6]  = '{4'b0001, 5'b10001, 16'h0020, 16'h4444, 3'd2, 3'd0, 3'd1, 3'd1, 1'b1, K_LOAD, 1'b0, 4'd0, 4'd1};
      tbl[7]  = '{4'b0001, 5'b10000, 16'h0021, 16'h5555, 3'd3, 3'd5, 3'd0, 3'd0, 1'b1, K_LOAD, 1'b0, 4'd0, 4'd1};
      tbl[8]  = '{4'b0001, 5'b10001, 16'h0030, 16'h6666, 3'd5, 3'd3, 3'd0, 3'd0, 1'b0, K_LOAD, 1'b0, 4'd0, 4'd1};
      tbl[9]  = '{4'b0001, 5'b10000, 16'h0031, 16'h7777, 3'd6, 3'd6, 3'd1, 3'd3, 1'b0, K_LOAD, 1'b0, 4'd0, 4'd1};
      tbl[10] = '{4'b0001, 5'b10001, 16'h0040, 16'h8888, 3'd7, 3'd3, 3'd0, 3'd0, 1'b0, K_LOAD, 1'b0, 4'd0, 4'd1};
      tbl[11] = '{4'b0001, 5'b00010, 16'h0041, 16'h9999, 3'd0, 3'd0, 3'd1, 3'd3, 1'b1, K_BUB,  1'b1, 4'd0, 4'd2};
      tbl[12] = '{4'b0001, 5'b00010, 16'h0041, 16'h9999, 3'd0, 3'd0, 3'd1, 3'd3, 1'b1, K_LOAD, 1'b0, 4'd0, 4'd2};
      tbl[13] = '{4'b0000, 5'b11111, 16'h0050, 16'haaaa, 3'd1, 3'd7, 3'd7, 3'd7, 1'b1, K_LOAD, 1'b0, 4'd0, 4'd2};
      tbl[14] = '{4'b0001, 5'b10001, 16'h0060, 16'hbbbb, 3'd2, 3'd3, 3'd0, 3'd0, 1'b0, K_LOAD, 1'b0, 4'd0, 4'd2};
      tbl[15] = '{4'b0111, 5'b10000, 16'h0061, 16'hcccc, 3'd3, 3'd4, 3'd3, 3'd0, 1'b0, K_HOLD, 1'b0, 4'd1, 4'd2};
      tbl[16] = '{4'b0111, 5'b10000, 16'h0062, 16'hc0c0, 3'd5, 3'd6, 3'd3, 3'd0, 1'b0, K_HOLD, 1'b0, 4'd2, 4'd2};
      tbl[17] = '{4'b0111, 5'b11000, 16'h0063, 16'hc1c1, 3'd6, 3'd1, 3'd3, 3'd0, 1'b0, K_HOLD, 1'b0, 4'd3, 4'd2};
      tbl[18] = '{4'b0011, 5'b10000, 16'h0064, 16'hdddd, 3'd3, 3'd4, 3'd3, 3'd0, 1'b0, K_BUB,  1'b1, 4'd3, 4'd3};
      tbl[19] = '{4'b0001, 5'b10000, 16'h0064, 16'hdddd, 3'd3, 3'd4, 3'd3, 3'd0, 1'b0, K_LOAD, 1'b0, 4'd3, 4'd3};
      tbl[20] = '{4'b0011, 5'b10000, 16'h0070, 16'heeee, 3'd4, 3'd5, 3'd0, 3'd0, 1'b0, K_BUB,  1'b0, 4'd3, 4'd4};
      tbl[21] = '{4'b0001, 5'b10001, 16'h0080, 16'h1234, 3'd5, 3'd3, 3'd0, 3'd0, 1'b0, K_LOAD, 1'b0, 4'd3, 4'd4};
      tbl[22] = '{4'b1001, 5'b10000, 16'h0081, 16'h4321, 3'd6, 3'd4, 3'd3, 3'd0, 1'b0, K_RST,  1'b0, 4'd0, 4'd0};

      prev_exp = '0;
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         check_bit($sformatf("hazard_v%0d", i), hazard_stall, tbl[i].hz);
         e = prev_exp;
         case (tbl[i].kind)
            K_RST:  e = '0;
            K_HOLD: e = prev_exp;
            K_BUB:  begin e.vld = 1'b0; e.ctl = '0; end
            default: begin
               e.vld = tbl[i].mode[0];
               e.ctl = tbl[i].ctl & {5{tbl[i].mode[0]}};
               e.npc = tbl[i].npc;
               e.imm = tbl[i].imm;
               e.a1  = tbl[i].imm ^ 16'h00ff;
               e.a2  = ~tbl[i].imm;
               e.r2  = tbl[i].npc + tbl[i].imm;
               e.op  = tbl[i].op;
               e.wa  = tbl[i].wa;
            end
         endcase
         e.stc = tbl[i].stc;
         e.bub = tbl[i].bub;
         sb_q.push_back(e);
         prev_exp = e;
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         a = actual();
         n_chk++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs_v%0d: got %h, expected %h", i, a, e);
         end
      end

      // Long stall run: counter must stop at 15 and outputs stay at reset values
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         rst      = 1'b0;
         stall_in = 1'b1;
         flush_in = 1'b1;
         nPC_in   = nPC_in + 16'd1;
         @(posedge clk);
         #1;
         check_cnt($sformatf("stall_sat_%0d", k), stall_cnt, (k < 15) ? 4'(k) : 4'd15);
         if (k == 20) begin
            check_cnt("bubble_during_stall", bubble_cnt, 4'd0);
            check_bit("valid_held_stall", valid_out, 1'b0);
            check_cnt("npc_held_stall", nPC_out[3:0], 4'd0);
         end
      end

      // Reset while stalled clears everything
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_cnt("stall_cnt_rst_mid_stall", stall_cnt, 4'd0);
      check_bit("hazard_in_rst", hazard_stall, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_exe_pipe_reg.md
Name: id_exe_pipe_reg

Overview:
Parametrised ID/EXE pipeline register for the miCPU core, replacing the free-running version. Adds synchronous reset, a valid bit, hold (stall) and bubble (flush) control, and a built-in load-use hazard detector that requests an upstream stall. Also keeps saturating stall and bubble counters for performance debug. Sits between decode/regfile read and the ALU/EXE stage.

Parameters:
DSIZE, 16, data/immediate/operand width
ISIZE, 16, PC width
ASIZE, 3, register address width
OPSIZE, 3, ALU opcode width
CNTW, 16, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
stall_in  in  1  EXE/downstream stall: hold all registers
flush_in  in  1  squash the incoming ID instruction (e.g. taken branch)
valid_in  in  1  ID holds a real instruction
wen_in, branch_in, mem_to_reg_in, mem_write_in, mem_read_in  in  1 each  decode controls
nPC_in  in  ISIZE  next PC
imm_extended_in  in  DSIZE  extended immediate
rdata1_in  in  DSIZE  ALU operand 1
rdata2_imm_sel_in  in  DSIZE  ALU operand 2 (reg or imm)
rdata2_in  in  DSIZE  store data
opcode_in  in  OPSIZE  ALU opcode
waddr_in  in  ASIZE  destination register
rs1_in, rs2_in  in  ASIZE  ID source registers
rs2_used_in  in  1  rs2 is a true source (R-type/store)
valid_out  out  1  EXE entry is real
wen_out, branch_out, mem_to_reg_out, mem_write_out, mem_read_out  out  1 each
nPC_out  out  ISIZE
imm_extended_out  out  DSIZE
alu_in1, alu_in2, rdata2_out  out  DSIZE
opcode_out  out  OPSIZE
waddr_out  out  ASIZE
hazard_stall  out  1  combinational: IF/ID must hold this cycle
stall_cnt  out  CNTW  cycles with stall_in=1
bubble_cnt  out  CNTW  bubbles inserted

Behaviour:
- Per-edge priority: rst > stall_in > flush_in/hazard bubble > normal load.
- rst: valid_out and all control outputs (wen, branch, mem_to_reg, mem_write, mem_read) = 0. Data outputs (nPC, imm, alu_in1/2, rdata2, opcode, waddr) = 0. Both counters = 0. rst mid-stall or mid-hazard wins unconditionally.
- stall_in=1 (no rst): every output register holds, including valid_out. No bubble is inserted even if flush_in or hazard is asserted. stall_cnt increments.
- bubble: when stall_in=0 and (flush_in=1 or hazard_stall=1):
  - valid_out and all five control outputs go to 0.
  - Data outputs hold their previous values (don't-care).
  - bubble_cnt increments.
  - flush and hazard in the same cycle count as one bubble.
- normal: all fields load from inputs; valid_out <= valid_in. If valid_in=0, control outputs are forced to 0.
- Latency: 1 cycle input to output.
- hazard_stall (combinational) = valid_out & mem_read_out & wen_out & (waddr_out != 0) & valid_in & ((waddr_out == rs1_in) | (rs2_used_in & (waddr_out == rs2_in))).
  - hazard_stall is gated to 0 while stall_in=1 or rst=1.
  - Register 0 never causes a hazard.
  - A load-use pair yields exactly one bubble, because the next cycle EXE holds that bubble (valid_out=0).
- Counters saturate at 2^CNTW-1; they do not wrap.

Test Plan:
- rst=1 for 2 cycles with all inputs at 1s -> after the edge all outputs are 0, counters 0, hazard_stall=0.
- Normal flow: load nPC_in=0x0010, opcode_in=3, waddr_in=2, wen_in=1, valid_in=1 -> next cycle nPC_out=0x0010, opcode_out=3, waddr_out=2, wen_out=1, valid_out=1.
- Load-use: EXE holds a load (mem_read=1, wen=1, waddr=3), ID has rs1_in=3 -> hazard_stall=1 that cycle. Next edge: valid_out=0, mem_read_out=0, bubble_cnt=1, hazard_stall=0. The following edge loads the dependent instruction.
- Same as above but waddr_out=0, or rs2_in=3 with rs2_used_in=0 -> hazard_stall=0, no bubble.
- stall_in=1 for 3 cycles with flush_in=1 and changing inputs -> outputs unchanged, stall_cnt=3, bubble_cnt unchanged. After release with flush_in=1 -> valid_out=0, bubble_cnt+1.
- Saturation (CNTW=4): 20 consecutive stall cycles -> stall_cnt=15 and stays 15.
